// File: rtl/sram1024x18_pkg.sv
// Shared constants and FSM state type for the sram1024x18 port arbiter.
package sram1024x18_pkg;

  localparam int SRAM_AW    = 10;
  localparam int SRAM_DW    = 18;
  localparam int SRAM_DEPTH = 1024;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr
// (wrapping) wins. The pointer itself is owned by the caller.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  // Scan N positions starting at ptr; first hit wins.
  always_comb begin
    logic found;
    int   j;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sram1024x18_port_arbiter.sv
// Shares one sram1024x18 port among NREQ requesters with round-robin
// arbitration, tagged read responses and a full-array clear engine.
//
// Handshake: a request from requester i is transferred on a rising edge
// where req_valid[i] & req_ready[i] are both high. req_ready is a
// combinational function of req_valid, the priority pointer and the FSM
// state; it is never high unless the matching req_valid is high. Read
// responses carry no ready: rsp_valid is high for exactly one cycle.
module sram1024x18_port_arbiter
  import sram1024x18_pkg::*;
#(
  parameter int                  NREQ      = 4,
  parameter logic [SRAM_DW-1:0]  CLR_VALUE = 18'h0,
  parameter int                  IDW       = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0]           req_we,
  input  logic [NREQ*SRAM_AW-1:0]   req_addr,
  input  logic [NREQ*SRAM_DW-1:0]   req_wdata,
  input  logic [NREQ*SRAM_DW-1:0]   req_wbe,
  output logic                      rsp_valid,
  output logic [IDW-1:0]            rsp_id,
  output logic [SRAM_DW-1:0]        rsp_rdata,
  input  logic                      clr_start,
  output logic                      clr_busy,
  output logic                      clr_done,
  output logic                      ram_cen,
  output logic                      ram_wen,
  output logic [SRAM_AW-1:0]        ram_addr,
  output logic [SRAM_DW-1:0]        ram_wmsk,
  output logic [SRAM_DW-1:0]        ram_wdata,
  input  logic [SRAM_DW-1:0]        ram_rdata,
  output state_t                    dbg_state
);

  state_t               state;
  logic [IDW-1:0]       ptr;
  logic [SRAM_AW-1:0]   cnt;
  logic                 rd_pend;
  logic [IDW-1:0]       rd_id;
  logic                 done_q;

  logic [NREQ-1:0]      arb_req;
  logic [NREQ-1:0]      gnt;
  logic [IDW-1:0]       gnt_idx;
  logic                 any_gnt;
  logic                 win_we;
  logic [IDW-1:0]       ptr_next;

  // Requests only compete in IDLE, out of reset, and when no clear is starting.
  always_comb begin
    arb_req = '0;
    if (!rst && state == ST_IDLE && !clr_start) arb_req = req_valid;
  end

  rr_arbiter #(.N(NREQ), .IW(IDW)) u_rr (
    .req     (arb_req),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign any_gnt   = |gnt;
  assign req_ready = gnt;
  assign win_we    = req_we[gnt_idx];
  assign ptr_next  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Macro pin mux: clear sweep, granted request, or idle (all deasserted).
  always_comb begin
    ram_cen   = 1'b1;
    ram_wen   = 1'b1;
    ram_addr  = '0;
    ram_wmsk  = '1;
    ram_wdata = '0;
    if (!rst && state == ST_CLEAR) begin
      ram_cen   = 1'b0;
      ram_wen   = 1'b0;
      ram_addr  = cnt;
      ram_wmsk  = '0;
      ram_wdata = CLR_VALUE;
    end else if (any_gnt) begin
      ram_cen   = 1'b0;
      ram_wen   = ~win_we;
      ram_addr  = req_addr[int'(gnt_idx)*SRAM_AW +: SRAM_AW];
      ram_wdata = req_wdata[int'(gnt_idx)*SRAM_DW +: SRAM_DW];
      ram_wmsk  = win_we ? ~req_wbe[int'(gnt_idx)*SRAM_DW +: SRAM_DW] : '1;
    end
  end

  // FSM, priority pointer, clear counter and read-response tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      cnt     <= '0;
      rd_pend <= 1'b0;
      rd_id   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      rd_pend <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clr_start) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end else if (any_gnt) begin
            ptr <= ptr_next;
            if (!win_we) begin
              rd_pend <= 1'b1;
              rd_id   <= gnt_idx;
            end
          end
        end
        ST_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == SRAM_AW'(SRAM_DEPTH - 1)) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = rd_pend;
  assign rsp_id    = rd_id;
  assign rsp_rdata = ram_rdata;
  assign clr_busy  = (state == ST_CLEAR);
  assign clr_done  = done_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_sram1024x18_port_arbiter.sv
// Directed bench for sram1024x18_port_arbiter with a behavioural macro model.
module tb_sram1024x18_port_arbiter;
  import sram1024x18_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam logic [17:0] CLR = 18'h2D5A5;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*10-1:0] req_addr;
  logic [NREQ*18-1:0] req_wdata;
  logic [NREQ*18-1:0] req_wbe;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [17:0]        rsp_rdata;
  logic               clr_start;
  logic               clr_busy;
  logic               clr_done;
  logic               ram_cen;
  logic               ram_wen;
  logic [9:0]         ram_addr;
  logic [17:0]        ram_wmsk;
  logic [17:0]        ram_wdata;
  logic [17:0]        ram_rdata;
  state_t             dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [17:0] mem [0:1023];
  logic [17:0] rd;

  sram1024x18_port_arbiter #(.NREQ(NREQ), .CLR_VALUE(CLR)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wbe   (req_wbe),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_rdata (rsp_rdata),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .ram_cen   (ram_cen),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_wmsk  (ram_wmsk),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: synchronous read, masked write (wmsk bit 0 = written).
  always @(posedge clk) begin
    if (!ram_cen) begin
      if (!ram_wen) mem[ram_addr] <= (mem[ram_addr] & ram_wmsk) | (ram_wdata & ~ram_wmsk);
      else          ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wbe   = '0;
  endtask

  task automatic set_req(input int id, input logic we, input logic [9:0] a,
                         input logic [17:0] d, input logic [17:0] be);
    req_valid[id]         = 1'b1;
    req_we[id]            = we;
    req_addr[id*10 +: 10] = a;
    req_wdata[id*18 +: 18] = d;
    req_wbe[id*18 +: 18]  = be;
  endtask

  task automatic write_word(input int id, input logic [9:0] a, input logic [17:0] d,
                            input logic [17:0] be);
    @(negedge clk);
    clear_reqs();
    set_req(id, 1'b1, a, d, be);
    #1 check("wr_ready", 32'(req_ready), 32'(1 << id));
    @(posedge clk);
    #1 clear_reqs();
  endtask

  task automatic read_word(input int id, input logic [9:0] a, output logic [17:0] d);
    @(negedge clk);
    clear_reqs();
    set_req(id, 1'b0, a, '0, '0);
    #1 check("rd_ready", 32'(req_ready), 32'(1 << id));
    @(posedge clk);
    #1 clear_reqs();
    @(negedge clk);
    #1;
    check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_rsp_id", 32'(rsp_id), 32'(id));
    d = rsp_rdata;
  endtask

  initial begin
    int busy;
    int done_cnt;
    int ready_bad;
    int n;

    for (int i = 0; i < 1024; i++) mem[i] = 18'h0;
    ram_rdata = '0;
    clear_reqs();
    clr_start = 1'b0;
    rst       = 1'b1;

    // Reset: requests are held off while rst is high
    @(negedge clk);
    req_valid = '1;
    #1 check("rst_ready_blocked", 32'(req_ready), 32'd0);
    check("rst_cen_blocked", 32'(ram_cen), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear_reqs();
    rst = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_clr_busy", 32'(clr_busy), 32'd0);
    check("rst_clr_done", 32'(clr_done), 32'd0);
    check("rst_ram_cen", 32'(ram_cen), 32'd1);
    check("rst_ram_wen", 32'(ram_wen), 32'd1);
    check("rst_ram_wmsk", 32'(ram_wmsk), 32'h3FFFF);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);

    // Round robin: all four read continuously for 8 cycles
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 10'(i), '0, '0);
      #1 check("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
      if (k > 0) begin
        check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rr_rsp_id", 32'(rsp_id), 32'((k - 1) % 4));
      end
    end
    @(negedge clk);
    clear_reqs();
    #1 check("rr_last_rsp_id", 32'(rsp_id), 32'd3);
    @(negedge clk);
    #1 check("rr_rsp_drops", 32'(rsp_valid), 32'd0);

    // Write then back-to-back read, requester 1
    @(negedge clk);
    set_req(1, 1'b1, 10'h155, 18'h2AAAA, 18'h3FFFF);
    #1;
    check("wr_ready1", 32'(req_ready), 32'b0010);
    check("wr_cen", 32'(ram_cen), 32'd0);
    check("wr_wen", 32'(ram_wen), 32'd0);
    check("wr_addr", 32'(ram_addr), 32'h155);
    check("wr_wdata", 32'(ram_wdata), 32'h2AAAA);
    check("wr_wmsk", 32'(ram_wmsk), 32'd0);
    @(posedge clk);
    #1 clear_reqs();
    @(negedge clk);
    set_req(1, 1'b0, 10'h155, '0, '0);
    #1;
    check("rd_wen", 32'(ram_wen), 32'd1);
    check("rd_wmsk", 32'(ram_wmsk), 32'h3FFFF);
    check("wr_no_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1 clear_reqs();
    @(negedge clk);
    #1;
    check("wrrd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("wrrd_rsp_id", 32'(rsp_id), 32'd1);
    check("wrrd_rdata", 32'(rsp_rdata), 32'h2AAAA);

    // Partial write mask
    write_word(3, 10'd7, 18'h3FFFF, 18'h3FFFF);
    write_word(0, 10'd7, 18'h00000, 18'h000FF);
    read_word(2, 10'd7, rd);
    check("mask_rdata", 32'(rd), 32'h3FF00);

    // Full clear with requester 2 contending
    @(negedge clk);
    clear_reqs();
    set_req(2, 1'b0, 10'd5, '0, '0);
    clr_start = 1'b1;
    #1;
    check("clr_start_blocks", 32'(req_ready), 32'd0);
    check("clr_start_cen", 32'(ram_cen), 32'd1);
    busy = 0; done_cnt = 0; ready_bad = 0; n = 0;
    while (n < 2000) begin
      @(negedge clk);
      clr_start = (busy == 500);
      #1;
      if (!clr_busy) break;
      busy++;
      if (req_ready != '0) ready_bad++;
      if (clr_done) done_cnt++;
      n++;
    end
    clr_start = 1'b0;
    check("clr_busy_len", 32'(busy), 32'd1024);
    check("clr_ready_zero", 32'(ready_bad), 32'd0);
    check("clr_done_early", 32'(done_cnt), 32'd0);
    check("clr_done_pulse", 32'(clr_done), 32'd1);
    check("clr_done_grant", 32'(req_ready), 32'b0100);
    @(posedge clk);
    #1 clear_reqs();
    @(negedge clk);
    #1;
    check("clr_done_once", 32'(clr_done), 32'd0);
    check("clr_grant_rsp_id", 32'(rsp_id), 32'd2);
    check("clr_grant_rdata", 32'(rsp_rdata), 32'(CLR));
    read_word(0, 10'd0, rd);
    check("clr_addr0", 32'(rd), 32'(CLR));
    read_word(1, 10'd511, rd);
    check("clr_addr511", 32'(rd), 32'(CLR));
    read_word(3, 10'd1023, rd);
    check("clr_addr1023", 32'(rd), 32'(CLR));

    // Reset in the middle of a clear
    write_word(0, 10'd99, 18'h00001, 18'h3FFFF);
    write_word(1, 10'd200, 18'h12345, 18'h3FFFF);
    @(negedge clk);
    clr_start = 1'b1;
    @(posedge clk);
    #1 clr_start = 1'b0;
    busy = 0; n = 0;
    while (n < 2000) begin
      @(negedge clk);
      #1;
      if (clr_busy) busy++;
      if (busy == 101) break;
      n++;
    end
    check("mid_cnt_reached", 32'(busy), 32'd101);
    rst = 1'b1;
    #1;
    check("mid_rst_cen", 32'(ram_cen), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("mid_busy_off", 32'(clr_busy), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      #1 if (clr_done) done_cnt++;
    end
    check("mid_no_done", 32'(done_cnt), 32'd0);
    read_word(0, 10'd99, rd);
    check("mid_addr99", 32'(rd), 32'(CLR));
    read_word(1, 10'd200, rd);
    check("mid_addr200", 32'(rd), 32'h12345);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
